// File: rtl/parking_sensor_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : parking_sensor_debounce (with parking_sensor_debounce_chan)
//  Description : Synchronises and debounces the two gate sensors (A outer,
//                B inner). Presents stable A/B levels plus change and
//                sequence-error strobes to the occupancy counter.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// One debounce channel. It exposes the level the debounced output will take
// on the next edge, so that the top can register the output and the strobes
// in the same cycle.
// ----------------------------------------------------------------------------
module parking_sensor_debounce_chan #(
  parameter int DB_CYCLES = 100000,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sync,
  output logic o_db_next
);

  typedef enum logic [1:0] {
    ST_ZERO  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_ONE   = 2'd2,
    ST_WAIT0 = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // State and counter registers; reset drops any partially counted change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_ZERO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: a new level needs DB_CYCLES consecutive samples, and
  // one opposite sample aborts the window back to the stable state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_ZERO: begin
        if (i_sync) begin
          w_state_nxt = ST_WAIT1;
          w_cnt_nxt   = c_CNT_ONE;
        end
      end
      ST_WAIT1: begin
        if (!i_sync) begin
          w_state_nxt = ST_ZERO;
        end else if (r_cnt == c_CNT_MAX) begin
          w_state_nxt = ST_ONE;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      ST_ONE: begin
        if (!i_sync) begin
          w_state_nxt = ST_WAIT0;
          w_cnt_nxt   = c_CNT_ONE;
        end
      end
      ST_WAIT0: begin
        if (i_sync) begin
          w_state_nxt = ST_ONE;
        end else if (r_cnt == c_CNT_MAX) begin
          w_state_nxt = ST_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_ZERO;
      end
    endcase
  end

  // Moore output of the next state: high in ONE and WAIT0.
  always_comb begin
    o_db_next = (w_state_nxt == ST_ONE) || (w_state_nxt == ST_WAIT0);
  end

endmodule

// ----------------------------------------------------------------------------
// Top: two-flop synchronisers, two independent channels, registered
// outputs and strobes. Bit 0 is channel A, bit 1 is channel B.
// ----------------------------------------------------------------------------
module parking_sensor_debounce #(
  parameter int DB_CYCLES = 100000,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_db,
  output logic b_db,
  output logic ab_change,
  output logic seq_err
);

  logic [1:0] r_s1;
  logic [1:0] r_s2;
  logic [1:0] w_db_next;
  logic [1:0] w_diff;
  logic [1:0] r_db;
  logic       r_ab_change;
  logic       r_seq_err;

  // Two-flop synchronisers for both raw sensor lines.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1 <= 2'b00;
      r_s2 <= 2'b00;
    end else begin
      r_s1 <= {b_raw, a_raw};
      r_s2 <= r_s1;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    parking_sensor_debounce_chan #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_sync    (r_s2[gi]),
      .o_db_next (w_db_next[gi])
    );
  end

  // Channels whose debounced level flips on the coming edge.
  always_comb begin
    w_diff = w_db_next ^ r_db;
  end

  // Registered levels and strobes, updated on the same edge; both channels
  // flipping together is a non-Gray step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_db        <= 2'b00;
      r_ab_change <= 1'b0;
      r_seq_err   <= 1'b0;
    end else begin
      r_db        <= w_db_next;
      r_ab_change <= |w_diff;
      r_seq_err   <= &w_diff;
    end
  end

  assign a_db      = r_db[0];
  assign b_db      = r_db[1];
  assign ab_change = r_ab_change;
  assign seq_err   = r_seq_err;

endmodule

`default_nettype wire
